// File: rtl/fp_add_sub_norm_round.sv
// ---------------------------------------------------------------------------
// fp_add_sub_norm_round
//   Back end of the pipelined FP32 adder/subtractor. Takes the coarse-shifted
//   sum and the leading-one shift count from the add/LOD stage, finishes the
//   normalization shift, adjusts the exponent, rounds to nearest-even,
//   classifies overflow/underflow and packs the IEEE-754 single result.
//   Two register stages with a valid/ready handshake and full backpressure.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready forced low in reset)
//   SumS_5              33-bit sum, already coarse-shifted by 16|0
//   Shift               total normalization shift (0..26), low 4 bits still
//                       to be applied here
//   PSgn                result sign
//   Emax                biased exponent of the larger operand
//   exc_valid/result    special-case word (NaN/Inf) that bypasses arithmetic
//   out_valid/out_ready downstream handshake
//   out_result          packed FP32 result
//   out_of, out_uf      overflow / underflow (flush-to-zero) flags
// ---------------------------------------------------------------------------
module fp_add_sub_norm_round #(
    parameter int EXP_W    = 8,
    parameter int FRAC_W   = 23,
    parameter int BIAS_MAX = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FRAC_W+9:0]       SumS_5,
    input  logic [4:0]              Shift,
    input  logic                    PSgn,
    input  logic [EXP_W-1:0]        Emax,
    input  logic                    exc_valid,
    input  logic [EXP_W+FRAC_W:0]   exc_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic                    out_of,
    output logic                    out_uf
);

    localparam int SUM_W  = FRAC_W + 10;          // hidden + frac + guard + 8 sticky
    localparam int WORD_W = EXP_W + FRAC_W + 1;
    localparam int E_W    = EXP_W + 2;            // signed, room for over/underflow
    localparam int G_IDX  = SUM_W - FRAC_W - 2;   // guard bit position

    localparam logic [E_W-1:0] E_OVF  = E_W'(BIAS_MAX);
    localparam logic [E_W-1:0] E_ZERO = '0;

    typedef struct packed {
        logic [SUM_W-1:0]  n;       // fully normalized sum
        logic [E_W-1:0]    e;       // adjusted exponent, two's complement
        logic              z;       // exact cancellation
        logic              sgn;
        logic              exc_v;
        logic [WORD_W-1:0] exc_res;
    } s1_t;

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv & ~rst;

    // ---------------------------------------------------------------------
    // Stage 1: fine shift + exponent adjust
    // ---------------------------------------------------------------------
    logic [SUM_W-1:0] lvl8, lvl4, lvl2, lvl1;
    s1_t              s1_new;
    s1_t              s1_q, s1_d;

    always_comb begin
        // Shift[4] was already consumed by the upstream 16|0 coarse shift,
        // so only the low four bits move the sum here.
        lvl8 = Shift[3] ? {SumS_5[SUM_W-9:0], 8'd0} : SumS_5;
        lvl4 = Shift[2] ? {lvl8[SUM_W-5:0],   4'd0} : lvl8;
        lvl2 = Shift[1] ? {lvl4[SUM_W-3:0],   2'd0} : lvl4;
        lvl1 = Shift[0] ? {lvl2[SUM_W-2:0],   1'b0} : lvl2;

        s1_new.n       = lvl1;
        // The sum carries one integer bit above the hidden position, hence +1.
        s1_new.e       = E_W'(Emax) + E_W'(1) - E_W'(Shift);
        s1_new.z       = (SumS_5 == '0);
        s1_new.sgn     = PSgn;
        s1_new.exc_v   = exc_valid;
        s1_new.exc_res = exc_result;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d = s1_new;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: round to nearest-even, classify, pack
    // ---------------------------------------------------------------------
    logic [FRAC_W-1:0] frac_raw;
    logic              guard, sticky, lsb, round_up;
    logic [FRAC_W:0]   frac_sum;
    logic [FRAC_W-1:0] frac_rnd;
    logic [E_W-1:0]    e_rnd;
    logic [WORD_W-1:0] res_new;
    logic              of_new, uf_new;

    // Hidden bit is implied by normalization and never stored.
    logic unused_hidden;
    assign unused_hidden = s1_q.n[SUM_W-1];

    always_comb begin
        frac_raw = s1_q.n[SUM_W-2:G_IDX+1];
        guard    = s1_q.n[G_IDX];
        sticky   = |s1_q.n[G_IDX-1:0];
        lsb      = s1_q.n[G_IDX+1];
        round_up = guard & (sticky | lsb);

        // Carry out of an all-ones fraction leaves frac=0 and bumps E.
        frac_sum = {1'b0, frac_raw} + {{FRAC_W{1'b0}}, round_up};
        frac_rnd = frac_sum[FRAC_W-1:0];
        e_rnd    = s1_q.e + E_W'(frac_sum[FRAC_W]);

        res_new = {s1_q.sgn, e_rnd[EXP_W-1:0], frac_rnd};
        of_new  = 1'b0;
        uf_new  = 1'b0;

        if (s1_q.exc_v) begin
            res_new = s1_q.exc_res;
        end else if (s1_q.z) begin
            // Exact cancellation is always +0 regardless of operand signs.
            res_new = '0;
        end else if ($signed(e_rnd) >= $signed(E_OVF)) begin
            res_new = {s1_q.sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            of_new  = 1'b1;
        end else if ($signed(e_rnd) <= $signed(E_ZERO)) begin
            // No denormals: anything below the smallest normal flushes to 0.
            res_new = {s1_q.sgn, {(WORD_W-1){1'b0}}};
            uf_new  = 1'b1;
        end
    end

    logic [WORD_W-1:0] res_q, res_d;
    logic              of_q, of_d;
    logic              uf_q, uf_d;

    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        of_d       = of_q;
        uf_d       = uf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d = res_new;
                of_d  = of_new;
                uf_d  = uf_new;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            res_q      <= '0;
            of_q       <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            res_q      <= res_d;
            of_q       <= of_d;
            uf_q       <= uf_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = res_q;
    assign out_of     = of_q;
    assign out_uf     = uf_q;

endmodule

// File: tb/tb_fp_add_sub_norm_round.sv
// ---------------------------------------------------------------------------
// tb_fp_add_sub_norm_round
//   Directed vector table, hand-written backpressure / reset sequences, and a
//   randomized run scored against an integer reference model.
// ---------------------------------------------------------------------------
module tb_fp_add_sub_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] SumS_5;
    logic [4:0]  Shift;
    logic        PSgn;
    logic [7:0]  Emax;
    logic        exc_valid;
    logic [31:0] exc_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_of;
    logic        out_uf;

    fp_add_sub_norm_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SumS_5     (SumS_5),
        .Shift      (Shift),
        .PSgn       (PSgn),
        .Emax       (Emax),
        .exc_valid  (exc_valid),
        .exc_result (exc_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_of     (out_of),
        .out_uf     (out_uf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [32:0] sum;
        logic [4:0]  sh;
        logic        sgn;
        logic [7:0]  emax;
        logic        excv;
        logic [31:0] excr;
        logic [31:0] res;
        logic        of;
        logic        uf;
    } vec_t;

    localparam int NV    = 15;
    localparam int NRAND = 400;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic vec_t mk(logic [32:0] sum, logic [4:0] sh, logic sgn,
                                logic [7:0] emax, logic excv, logic [31:0] excr,
                                logic [31:0] res, logic of, logic uf);
        vec_t v;
        v.sum = sum; v.sh = sh; v.sgn = sgn; v.emax = emax;
        v.excv = excv; v.excr = excr; v.res = res; v.of = of; v.uf = uf;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        SumS_5     = v.sum;
        Shift      = v.sh;
        PSgn       = v.sgn;
        Emax       = v.emax;
        exc_valid  = v.excv;
        exc_result = v.excr;
    endtask

    // Reference: value = N * 2^(e-bias), round the 24-bit significand by
    // comparing the discarded remainder with one half.
    function automatic logic [33:0] model(input vec_t v);
        logic [63:0] n, keep, rem;
        int          e;
        if (v.excv) return {2'b00, v.excr};
        if (v.sum == 33'd0) return 34'd0;
        n    = {31'd0, v.sum} << v.sh[3:0];
        n    = n & 64'h1_FFFF_FFFF;
        keep = n >> 9;
        rem  = n & 64'h1FF;
        e    = int'(v.emax) + 1 - int'(v.sh);
        if (rem > 64'h100 || (rem == 64'h100 && keep[0])) keep = keep + 1;
        if (keep >= 64'h100_0000) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {2'b10, v.sgn, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b01, v.sgn, 31'd0};
        return {2'b00, v.sgn, 8'(e), keep[22:0]};
    endfunction

    function automatic vec_t gen_rand();
        vec_t        v;
        logic [32:0] n;
        int          r, k;
        v      = '0;
        v.sh   = 5'($urandom_range(0, 26));
        v.sgn  = 1'($urandom_range(0, 1));
        r      = $urandom_range(0, 99);
        v.emax = (r < 15) ? 8'($urandom_range(0, 30)) :
                 (r < 30) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 255));
        v.excv = ($urandom_range(0, 19) == 0);
        v.excr = $urandom;
        n      = {1'b1, 32'($urandom)};
        r      = $urandom_range(0, 9);
        if (r == 0) n[8:0] = 9'h100;        // exact tie
        if (r == 1) n[31:8] = '1;           // rounding carry-out
        k      = int'(v.sh[3:0]);
        n      = (n >> k) << k;
        v.sum  = n >> k;                    // leading one lands on bit 32 after shift
        if ($urandom_range(0, 9) == 0) v.sum = '0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int i);
        int cyc;
        @(negedge clk);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk(in_ready === 1'b1, $sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk(cyc == 2, $sformatf("vec%0d_latency", i), 64'(cyc), 64'd2);
        chk({out_of, out_uf, out_result} === {v.of, v.uf, v.res},
            $sformatf("vec%0d_result", i),
            64'({out_of, out_uf, out_result}), 64'({v.of, v.uf, v.res}));
    endtask

    vec_t        vecs [NV];
    vec_t        rv;
    logic [33:0] sbq[$];
    logic [33:0] exp_w, held;
    logic [31:0] hold_res;
    bit          acc, stalled, hold_ok;
    int          sent, got, cyc, k, stale;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            sum             sh     s     emax   exc   excr            res            of    uf
        vecs[0]  = mk(33'h1_0000_0000, 5'd0,  1'b0, 8'd127, 1'b0, 32'h0,        32'h40000000, 1'b0, 1'b0);
        vecs[1]  = mk(33'h0_8000_0080, 5'd1,  1'b0, 8'd127, 1'b0, 32'h0,        32'h3F800000, 1'b0, 1'b0);
        vecs[2]  = mk(33'h0_8000_0180, 5'd1,  1'b0, 8'd127, 1'b0, 32'h0,        32'h3F800002, 1'b0, 1'b0);
        vecs[3]  = mk(33'h0,           5'd26, 1'b1, 8'd100, 1'b0, 32'h0,        32'h00000000, 1'b0, 1'b0);
        vecs[4]  = mk(33'h1_0000_0000, 5'd0,  1'b1, 8'd254, 1'b0, 32'h0,        32'hFF800000, 1'b1, 1'b0);
        vecs[5]  = mk(33'h0_0800_0000, 5'd5,  1'b0, 8'd3,   1'b0, 32'h0,        32'h00000000, 1'b0, 1'b1);
        vecs[6]  = mk(33'h1_0000_0000, 5'd0,  1'b0, 8'd254, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0);
        vecs[7]  = mk(33'h1_FFFF_FF80, 5'd0,  1'b0, 8'd127, 1'b0, 32'h0,        32'h40800000, 1'b0, 1'b0);
        vecs[8]  = mk(33'h1_FFFF_FF80, 5'd0,  1'b0, 8'd253, 1'b0, 32'h0,        32'h7F800000, 1'b1, 1'b0);
        vecs[9]  = mk(33'h1_0000_0000, 5'd0,  1'b0, 8'd0,   1'b0, 32'h0,        32'h00800000, 1'b0, 1'b0);
        vecs[10] = mk(33'h0_8000_0000, 5'd1,  1'b1, 8'd0,   1'b0, 32'h0,        32'h80000000, 1'b0, 1'b1);
        vecs[11] = mk(33'h1_0000_0000, 5'd16, 1'b0, 8'd127, 1'b0, 32'h0,        32'h38000000, 1'b0, 1'b0);
        vecs[12] = mk(33'h0,           5'd30, 1'b0, 8'd50,  1'b0, 32'h0,        32'h00000000, 1'b0, 1'b0);
        vecs[13] = mk(33'h1_0000_027F, 5'd0,  1'b0, 8'd127, 1'b0, 32'h0,        32'h40000001, 1'b0, 1'b0);
        vecs[14] = mk(33'h1_0000_0181, 5'd0,  1'b0, 8'd127, 1'b0, 32'h0,        32'h40000001, 1'b0, 1'b0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive('0);

        // Reset state
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        #1;
        chk(in_ready === 1'b0, "rst_in_ready", 64'(in_ready), 64'd0);
        chk({out_valid, out_of, out_uf, out_result} === 35'd0, "rst_outputs",
            64'({out_valid, out_of, out_uf, out_result}), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Backpressure: three beats offered into a stalled pipe
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[0]); in_valid = 1'b1; #1;
        chk(in_ready === 1'b1, "bp_acc0", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(vecs[1]); #1;
        chk(in_ready === 1'b1, "bp_acc1", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(vecs[2]); #1;
        chk(in_ready === 1'b0, "bp_full_stall", 64'(in_ready), 64'd0);
        hold_res = out_result;
        hold_ok  = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            if (!(out_valid && out_result == hold_res && !in_ready)) hold_ok = 1'b0;
        end
        chk(hold_ok, "bp_hold_stable", 64'(out_result), 64'(hold_res));
        chk(out_valid && out_result == vecs[0].res, "bp_head", 64'(out_result), 64'(vecs[0].res));
        out_ready = 1'b1; #1;
        chk(in_ready === 1'b1, "bp_release_ready", 64'(in_ready), 64'd1);
        k = 0; cyc = 0;
        while (k < 3 && cyc < 10) begin
            if (out_valid) begin
                chk(out_result == vecs[k].res, $sformatf("bp_order%0d", k),
                    64'(out_result), 64'(vecs[k].res));
                k++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
            #1;
        end
        chk(k == 3, "bp_drain_count", 64'(k), 64'd3);

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        drive(vecs[1]); in_valid = 1'b1;
        @(negedge clk);
        drive(vecs[2]);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1; #1;
        chk(in_ready === 1'b0, "rst_mid_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk({out_valid, out_of, out_uf, out_result} === 35'd0, "rst_mid_outputs",
            64'({out_valid, out_of, out_uf, out_result}), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk(stale == 0, "rst_no_stale", 64'(stale), 64'd0);

        // Randomized traffic against the reference model
        sent = 0; got = 0; cyc = 0; acc = 1'b0; stalled = 1'b0; held = '0;
        rv = '0;
        while (got < NRAND && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (stalled)
                chk(out_valid && {out_of, out_uf, out_result} == held, "rand_hold",
                    64'({out_valid, out_of, out_uf, out_result}), 64'({1'b1, held}));
            if (acc) in_valid = 1'b0;
            acc = 1'b0;
            if (!in_valid && sent < NRAND && $urandom_range(0, 9) < 7) begin
                rv = gen_rand();
                drive(rv);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk(1'b0, "rand_unexpected", 64'({out_of, out_uf, out_result}), 64'd0);
                end else begin
                    exp_w = sbq.pop_front();
                    chk({out_of, out_uf, out_result} == exp_w, "rand_result",
                        64'({out_of, out_uf, out_result}), 64'(exp_w));
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_of, out_uf, out_result};
            if (in_valid && in_ready) begin
                sbq.push_back(model(rv));
                sent++;
                acc = 1'b1;
            end
        end
        chk(got == NRAND && sbq.size() == 0, "rand_drain", 64'(got), 64'(NRAND));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
